// File: rtl/prod_arb_pkg.sv
// -----------------------------------------------------------------------------
// prod_arb_pkg
// Shared constants and types for the two-input producer arbiter/merger.
//   PROD_DATA_W    default data width of every data port
//   DEPTH_DEF      default entries per input FIFO
//   PTR_W          FIFO pointer width for the default depth
//   PROD_*         producer traffic limits (data range, burst and idle
//                  lengths); benches reuse these to build producer models
//   out_state_e    output register state: IDLE (out_val=0) / HOLD (out_val=1)
// Related optional feature macro (used by prod_arb): PROD_ARB_DROP_CNT_EN
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package prod_arb_pkg;

   localparam int PROD_DATA_W    = 8;
   localparam int DEPTH_DEF      = 4;
   localparam int PTR_W          = $clog2(DEPTH_DEF);

   localparam int PROD_DATA_MAX  = 5;
   localparam int PROD_VALID_MIN = 3;
   localparam int PROD_VALID_MAX = 5;
   localparam int PROD_IDLE_MIN  = 1;
   localparam int PROD_IDLE_MAX  = 4;

   typedef enum logic {
      OUT_IDLE = 1'b0,
      OUT_HOLD = 1'b1
   } out_state_e;

endpackage

// File: rtl/prod_fifo.sv
// -----------------------------------------------------------------------------
// prod_fifo
// Small synchronous FIFO buffering one producer ahead of the arbiter.
// The head word is presented combinationally so the arbiter can register it
// in the same cycle it pops.
// Ports:
//   clk    clock, all state updates on posedge
//   rst_b  asynchronous active-low reset (clears pointers and count)
//   push   write din at this edge (caller guarantees space or a same-edge pop)
//   din    write data
//   pop    advance the head at this edge (caller guarantees non-empty)
//   dout   current head word (combinational)
//   count  number of stored words, 0..DEPTH
//   full   count == DEPTH
//   empty  count == 0
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module prod_fifo
   import prod_arb_pkg::*;
#(
   parameter int DATA_W = PROD_DATA_W,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst_b,
   input  logic                   push,
   input  logic [DATA_W-1:0]      din,
   input  logic                   pop,
   output logic [DATA_W-1:0]      dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;

   // Storage has no reset: stale words are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == (PW + 1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/prod_arb.sv
// -----------------------------------------------------------------------------
// prod_arb
// Two-input round-robin arbiter/merger. Each producer pushes into its own
// FIFO (producers cannot be stalled); one registered valid/ready output
// stream drains both FIFOs towards a single consumer.
// Ports:
//   clk        clock, all state updates on posedge
//   rst_b      asynchronous active-low reset
//   val0/data0 producer 0 word strobe and data
//   val1/data1 producer 1 word strobe and data
//   out_rdy    consumer ready
//   out_val    output word valid
//   out_data   output word
//   out_src    producer index of out_data
//   ovf        sticky overflow flags, bit i for input i, cleared by reset only
//   drop_cnt0/drop_cnt1  (only with PROD_ARB_DROP_CNT_EN) saturating 8-bit
//                        counts of dropped words per input
// Optional feature macro: PROD_ARB_DROP_CNT_EN
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module prod_arb
   import prod_arb_pkg::*;
#(
   parameter int DATA_W = PROD_DATA_W,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              val0,
   input  logic [DATA_W-1:0] data0,
   input  logic              val1,
   input  logic [DATA_W-1:0] data1,
   input  logic              out_rdy,
   output logic              out_val,
   output logic [DATA_W-1:0] out_data,
   output logic              out_src,
`ifdef PROD_ARB_DROP_CNT_EN
   output logic [7:0]        drop_cnt0,
   output logic [7:0]        drop_cnt1,
`endif
   output logic [1:0]        ovf
);

   localparam int PW = $clog2(DEPTH);

   logic [1:0]          val_v;
   logic [1:0]          push_v;
   logic [1:0]          pop_v;
   logic [1:0]          drop_v;
   logic [1:0]          full_v;
   logic [1:0]          empty_v;
   logic [DATA_W-1:0]   din_v  [2];
   logic [DATA_W-1:0]   dout_v [2];
   // FIFO fill levels are only observed for debug; arbitration uses full/empty.
   logic [2*(PW+1)-1:0] count_unused;

   out_state_e          state;
   logic                rr_last;
   logic                load;
   logic                grant;
   logic [DATA_W-1:0]   head;

   assign val_v    = {val1, val0};
   assign din_v[0] = data0;
   assign din_v[1] = data1;

   // The output register may take a new word when empty or being drained.
   assign load = (state == OUT_IDLE) || out_rdy;

   // Single requester wins outright; on a tie the input not served last wins.
   always_comb begin
      grant = 1'b0;
      if (!empty_v[0] && !empty_v[1]) begin
         grant = ~rr_last;
      end else if (!empty_v[1]) begin
         grant = 1'b1;
      end
   end

   assign pop_v[0] = load && !empty_v[0] && !grant;
   assign pop_v[1] = load && !empty_v[1] &&  grant;
   assign head     = grant ? dout_v[1] : dout_v[0];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : gen_fifo
         // A full FIFO still accepts a word when its head leaves at the same edge.
         assign push_v[gi] = val_v[gi] && (!full_v[gi] || pop_v[gi]);
         assign drop_v[gi] = val_v[gi] && !push_v[gi];

         prod_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
         ) u_fifo (
            .clk   (clk),
            .rst_b (rst_b),
            .push  (push_v[gi]),
            .din   (din_v[gi]),
            .pop   (pop_v[gi]),
            .dout  (dout_v[gi]),
            .count (count_unused[gi*(PW+1) +: (PW+1)]),
            .full  (full_v[gi]),
            .empty (empty_v[gi])
         );
      end
   endgenerate

   // Output FSM: IDLE <-> HOLD. While stalled (HOLD, !out_rdy) nothing moves.
   // rr_last resets to 1 so input 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state    <= OUT_IDLE;
         out_data <= '0;
         out_src  <= 1'b0;
         rr_last  <= 1'b1;
         ovf      <= 2'b00;
      end else begin
         ovf <= ovf | drop_v;
         if (load) begin
            if (!empty_v[0] || !empty_v[1]) begin
               state    <= OUT_HOLD;
               out_data <= head;
               out_src  <= grant;
               rr_last  <= grant;
            end else begin
               state <= OUT_IDLE;
            end
         end
      end
   end

   assign out_val = (state == OUT_HOLD);

`ifdef PROD_ARB_DROP_CNT_EN
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         drop_cnt0 <= 8'd0;
         drop_cnt1 <= 8'd0;
      end else begin
         if (drop_v[0] && (drop_cnt0 != 8'hFF)) drop_cnt0 <= drop_cnt0 + 8'd1;
         if (drop_v[1] && (drop_cnt1 != 8'hFF)) drop_cnt1 <= drop_cnt1 + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_prod_arb.sv
// -----------------------------------------------------------------------------
// tb_prod_arb
// Self-checking bench for prod_arb. Expected output words are queued when the
// stimulus is driven and compared when the DUT hands a word to the consumer.
// Honours PROD_ARB_DROP_CNT_EN for the optional drop counters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_prod_arb;
   import prod_arb_pkg::*;

   localparam int DW = PROD_DATA_W;
   localparam int DP = DEPTH_DEF;

   logic          clk     = 1'b0;
   logic          rst_b   = 1'b0;
   logic          val0    = 1'b0;
   logic          val1    = 1'b0;
   logic [DW-1:0] data0   = '0;
   logic [DW-1:0] data1   = '0;
   logic          out_rdy = 1'b0;
   logic          out_val;
   logic [DW-1:0] out_data;
   logic          out_src;
   logic [1:0]    ovf;
`ifdef PROD_ARB_DROP_CNT_EN
   logic [7:0]    drop_cnt0;
   logic [7:0]    drop_cnt1;
`endif

   typedef struct packed {
      logic          src;
      logic [DW-1:0] data;
   } xfer_t;

   xfer_t         exp_q[$];
   logic [DW-1:0] rq0[$];
   logic [DW-1:0] rq1[$];
   bit            rnd_mode = 1'b0;
   int            checks   = 0;
   int            errors   = 0;

   always #5 clk = ~clk;

   prod_arb #(
      .DATA_W (DW),
      .DEPTH  (DP)
   ) dut (
      .clk      (clk),
      .rst_b    (rst_b),
      .val0     (val0),
      .data0    (data0),
      .val1     (val1),
      .data1    (data1),
      .out_rdy  (out_rdy),
      .out_val  (out_val),
      .out_data (out_data),
      .out_src  (out_src),
`ifdef PROD_ARB_DROP_CNT_EN
      .drop_cnt0(drop_cnt0),
      .drop_cnt1(drop_cnt1),
`endif
      .ovf      (ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      val0    = 1'b0;
      val1    = 1'b0;
      out_rdy = 1'b0;
      rst_b   = 1'b0;
      exp_q.delete();
      rq0.delete();
      rq1.delete();
      #25;
      rst_b = 1'b1;
      step();
   endtask

   // Random mode: match against the per-source queue; words may only be
   // skipped when that source has flagged an overflow.
   task automatic rnd_match();
      logic found;
      found = 1'b0;
      chk("rnd_range", 32'(out_data <= DW'(PROD_DATA_MAX)), 1);
      if (out_src == 1'b0) begin
         while (!found && rq0.size() > 0) begin
            if (rq0[0] == out_data) found = 1'b1;
            else if (ovf[0])        void'(rq0.pop_front());
            else                    break;
         end
         if (found) void'(rq0.pop_front());
      end else begin
         while (!found && rq1.size() > 0) begin
            if (rq1[0] == out_data) found = 1'b1;
            else if (ovf[1])        void'(rq1.pop_front());
            else                    break;
         end
         if (found) void'(rq1.pop_front());
      end
      chk("rnd_order", 32'(found), 1);
   endtask

   // Transfer monitor: a word moves when out_val && out_rdy at the next edge.
   always @(negedge clk) begin
      if (rst_b && out_val && out_rdy) begin
         $display("XFER t=%0t src=%0d data=%0d", $time, out_src, out_data);
         if (rnd_mode) begin
            rnd_match();
         end else if (exp_q.size() == 0) begin
            chk("xfer_unexpected", 32'(out_data), 32'hFFFF_FFFF);
         end else begin
            xfer_t e;
            e = exp_q.pop_front();
            chk("xfer_src",  32'(out_src),  32'(e.src));
            chk("xfer_data", 32'(out_data), 32'(e.data));
         end
      end
   end

   initial begin
      int   rem0;
      int   rem1;
      bit   on0;
      bit   on1;

      #22;
      rst_b = 1'b1;
      step();

      // Reset state
      chk("rst_out_val",  32'(out_val),  0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_src",  32'(out_src),  0);
      chk("rst_ovf",      32'(ovf),      0);

      // Single source, latency and back-to-back output
      out_rdy = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         val0  = 1'b1;
         data0 = DW'(i);
         exp_q.push_back('{src: 1'b0, data: DW'(i)});
         step();
         chk("t1_out_val", 32'(out_val), (i == 1) ? 0 : 1);
      end
      val0 = 1'b0;
      step();
      chk("t1_out_val_last", 32'(out_val), 1);
      step();
      chk("t1_out_val_idle", 32'(out_val), 0);
      chk("t1_ovf", 32'(ovf), 0);
      chk("t1_drained", exp_q.size(), 0);

      // Simultaneous sources, round-robin from input 0
      do_reset();
      out_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         val0  = 1'b1;
         val1  = 1'b1;
         data0 = DW'(i);
         data1 = DW'(5 - i);
         exp_q.push_back('{src: 1'b0, data: DW'(i)});
         exp_q.push_back('{src: 1'b1, data: DW'(5 - i)});
         step();
      end
      val0 = 1'b0;
      val1 = 1'b0;
      steps(10);
      chk("t2_drained", exp_q.size(), 0);
      chk("t2_ovf", 32'(ovf), 0);

      // Stall with overflow on input 0
      do_reset();
      out_rdy = 1'b0;
      for (int i = 0; i < 6; i++) begin
         val0  = 1'b1;
         data0 = DW'(i);
         if (i < 5) exp_q.push_back('{src: 1'b0, data: DW'(i)});
         step();
      end
      val0 = 1'b0;
      chk("t3_out_val", 32'(out_val), 1);
      chk("t3_out_data", 32'(out_data), 0);
      chk("t3_ovf", 32'(ovf), 1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t3_hold_data", 32'(out_data), 0);
         chk("t3_hold_val",  32'(out_val),  1);
      end
`ifdef PROD_ARB_DROP_CNT_EN
      chk("t3_drop_cnt0", 32'(drop_cnt0), 1);
`endif
      out_rdy = 1'b1;
      steps(8);
      chk("t3_drained", exp_q.size(), 0);
      chk("t3_ovf_sticky", 32'(ovf), 1);

      // Full FIFO 1 accepts a push when popped at the same edge
      do_reset();
      out_rdy = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         val1  = 1'b1;
         data1 = DW'(i);
         exp_q.push_back('{src: 1'b1, data: DW'(i)});
         step();
      end
      chk("t4_count_full", 32'(dut.gen_fifo[1].u_fifo.count), DP);
      val1    = 1'b1;
      data1   = DW'(6);
      out_rdy = 1'b1;
      exp_q.push_back('{src: 1'b1, data: DW'(6)});
      step();
      val1 = 1'b0;
      chk("t4_count_kept", 32'(dut.gen_fifo[1].u_fifo.count), DP);
      chk("t4_ovf", 32'(ovf), 0);
      steps(8);
      chk("t4_drained", exp_q.size(), 0);

      // Asynchronous reset mid-stream
      do_reset();
      out_rdy = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         val0  = 1'b1;
         data0 = DW'(i);
         step();
      end
      val0 = 1'b0;
      chk("t5_pre_val", 32'(out_val), 1);
      chk("t5_pre_ovf", 32'(ovf), 1);
      #2;
      rst_b = 1'b0;
      exp_q.delete();
      #1;
      chk("t5_async_val",  32'(out_val),  0);
      chk("t5_async_data", 32'(out_data), 0);
      chk("t5_async_ovf",  32'(ovf),      0);
      #24;
      rst_b = 1'b1;
      step();
      val0    = 1'b1;
      val1    = 1'b1;
      data0   = DW'(2);
      data1   = DW'(4);
      out_rdy = 1'b1;
      exp_q.push_back('{src: 1'b0, data: DW'(2)});
      exp_q.push_back('{src: 1'b1, data: DW'(4)});
      step();
      val0 = 1'b0;
      val1 = 1'b0;
      steps(6);
      chk("t5_drained", exp_q.size(), 0);
      chk("t5_idle", 32'(out_val), 0);

      // Random producers with random consumer ready
      do_reset();
      rnd_mode = 1'b1;
      rem0 = 0;
      rem1 = 0;
      on0  = 1'b0;
      on1  = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (rem0 == 0) begin
            on0  = !on0;
            rem0 = on0 ? int'($urandom_range(PROD_VALID_MAX, PROD_VALID_MIN))
                       : int'($urandom_range(PROD_IDLE_MAX, PROD_IDLE_MIN));
         end
         rem0--;
         if (rem1 == 0) begin
            on1  = !on1;
            rem1 = on1 ? int'($urandom_range(PROD_VALID_MAX, PROD_VALID_MIN))
                       : int'($urandom_range(PROD_IDLE_MAX, PROD_IDLE_MIN));
         end
         rem1--;
         val0 = on0;
         val1 = on1;
         if (on0) begin
            data0 = DW'($urandom_range(PROD_DATA_MAX, 0));
            rq0.push_back(data0);
         end
         if (on1) begin
            data1 = DW'($urandom_range(PROD_DATA_MAX, 0));
            rq1.push_back(data1);
         end
         out_rdy = 1'($urandom_range(1, 0));
         step();
      end
      val0    = 1'b0;
      val1    = 1'b0;
      out_rdy = 1'b1;
      steps(30);
      chk("rnd_drain0", 32'((rq0.size() == 0) || ovf[0]), 1);
      chk("rnd_drain1", 32'((rq1.size() == 0) || ovf[1]), 1);
      chk("rnd_idle", 32'(out_val), 0);
      rnd_mode = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
